// File: rtl/pipe_pkg.sv
// Shared types for the 8-bit pipeline: data/register widths, the memory-stage
// state encoding and the MEM/WB boundary bundle.
package pipe_pkg;

  localparam int DATA_W = 8;
  localparam int REG_W  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic              reg_write;
    logic              result_src;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mem_data;
    logic [REG_W-1:0]  rd;
  } memwb_t;

  // A slot needs the data memory when it is real and reads or writes it.
  function automatic logic is_access(input logic valid, input logic rd_en,
                                     input logic wr_en);
    return valid & (rd_en | wr_en);
  endfunction

endpackage

// File: rtl/mem_access_fsm.sv
// Request/acknowledge sequencer for data-memory accesses: holds the request
// registers, the bounded-wait counter and produces stall/complete/timeout.
module mem_access_fsm
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              valid_i,
  input  logic              reg_write_i,
  input  logic              result_src_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_W-1:0]  rd_i,
  input  logic              flush_i,
  input  logic              mem_ack_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_err_o,
  output logic              stall_o,
  output logic              complete_o,
  output logic              timeout_o,
  output mem_state_t        state_o,
  output logic              lat_reg_write_o,
  output logic              lat_result_src_o,
  output logic [REG_W-1:0]  lat_rd_o
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic              rw_q, rw_d;
  logic              rs_q, rs_d;
  logic              err_q, err_d;

  logic accept, in_wait, complete, timeout;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      rs_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      rs_q    <= rs_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    in_wait  = (state_q == WAIT);
    accept   = (state_q == IDLE) & is_access(valid_i, mem_read_i, mem_write_i) & ~flush_i;
    complete = in_wait & mem_ack_i;
    // Ack wins over timeout when both land in the same cycle.
    timeout  = in_wait & ~mem_ack_i & (cnt_q == CNT_MAX);

    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    rs_d    = rs_q;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WAIT;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = mem_write_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          rd_d    = rd_i;
          rw_d    = reg_write_i;
          rs_d    = result_src_i;
        end
      end
      WAIT: begin
        if (complete || timeout) begin
          state_d = IDLE;
          cnt_d   = '0;
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          rd_d    = '0;
          rw_d    = 1'b0;
          rs_d    = 1'b0;
          err_d   = timeout;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall_o          = accept | (in_wait & ~mem_ack_i & ~timeout);
  assign complete_o       = complete;
  assign timeout_o        = timeout;
  assign state_o          = state_q;
  assign mem_req_o        = req_q;
  assign mem_we_o         = we_q;
  assign mem_addr_o       = addr_q;
  assign mem_wdata_o      = wdata_q;
  assign mem_err_o        = err_q;
  assign lat_reg_write_o  = rw_q;
  assign lat_result_src_o = rs_q;
  assign lat_rd_o         = rd_q;

endmodule

// File: rtl/stage_mem.sv
// Memory-access pipeline stage: drives the data-memory handshake through
// mem_access_fsm and registers the retiring instruction into MEM/WB.
module stage_mem
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_MEM,
  input  logic              RegWrite_MEM,
  input  logic              ResultSrc_MEM,
  input  logic              MemRead_MEM,
  input  logic              MemWrite_MEM,
  input  logic [DATA_W-1:0] alu_result_MEM,
  input  logic [DATA_W-1:0] store_data_MEM,
  input  logic [REG_W-1:0]  rd_MEM,
  input  logic              flush,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              stall_MEM,
  output logic              mem_err,
  output logic              RegWrite_WB,
  output logic              ResultSrc_WB,
  output logic [DATA_W-1:0] alu_result_WB,
  output logic [DATA_W-1:0] mem_data_WB,
  output logic [REG_W-1:0]  rd_WB
);

  mem_state_t       fsm_state;
  logic             complete, timeout;
  logic             lat_reg_write, lat_result_src;
  logic [REG_W-1:0] lat_rd;
  logic             pass;
  memwb_t           memwb_q, memwb_d;

  mem_access_fsm #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_fsm (
    .clk_i           (clk),
    .reset_i         (reset),
    .valid_i         (valid_MEM),
    .reg_write_i     (RegWrite_MEM),
    .result_src_i    (ResultSrc_MEM),
    .mem_read_i      (MemRead_MEM),
    .mem_write_i     (MemWrite_MEM),
    .addr_i          (alu_result_MEM),
    .wdata_i         (store_data_MEM),
    .rd_i            (rd_MEM),
    .flush_i         (flush),
    .mem_ack_i       (mem_ack),
    .mem_req_o       (mem_req),
    .mem_we_o        (mem_we),
    .mem_addr_o      (mem_addr),
    .mem_wdata_o     (mem_wdata),
    .mem_err_o       (mem_err),
    .stall_o         (stall_MEM),
    .complete_o      (complete),
    .timeout_o       (timeout),
    .state_o         (fsm_state),
    .lat_reg_write_o (lat_reg_write),
    .lat_result_src_o(lat_result_src),
    .lat_rd_o        (lat_rd)
  );

  // Non-memory instructions only flow through while no access is outstanding.
  assign pass = (fsm_state == IDLE) & valid_MEM & ~MemRead_MEM & ~MemWrite_MEM & ~flush;

  always_comb begin
    memwb_d = '0;
    if (pass) begin
      memwb_d.reg_write  = RegWrite_MEM;
      memwb_d.result_src = ResultSrc_MEM;
      memwb_d.alu_result = alu_result_MEM;
      memwb_d.rd         = rd_MEM;
    end else if (complete) begin
      memwb_d.reg_write  = lat_reg_write;
      memwb_d.result_src = lat_result_src;
      memwb_d.alu_result = mem_addr;
      memwb_d.mem_data   = mem_we ? '0 : mem_rdata;
      memwb_d.rd         = lat_rd;
    end else if (timeout) begin
      // Abandoned access retires with its register write suppressed.
      memwb_d.result_src = lat_result_src;
      memwb_d.alu_result = mem_addr;
      memwb_d.rd         = lat_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) memwb_q <= '0;
    else       memwb_q <= memwb_d;
  end

  assign RegWrite_WB   = memwb_q.reg_write;
  assign ResultSrc_WB  = memwb_q.result_src;
  assign alu_result_WB = memwb_q.alu_result;
  assign mem_data_WB   = memwb_q.mem_data;
  assign rd_WB         = memwb_q.rd;

endmodule

// File: tb/tb_stage_mem.sv
// Self-checking bench for stage_mem: vector table, directed handshake
// sequences and randomized instructions against a transaction-level model.
module tb_stage_mem;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_MEM, RegWrite_MEM, ResultSrc_MEM, MemRead_MEM, MemWrite_MEM;
  logic [7:0] alu_result_MEM, store_data_MEM;
  logic [2:0] rd_MEM;
  logic       flush, mem_ack;
  logic [7:0] mem_rdata;
  logic       mem_req, mem_we, stall_MEM, mem_err;
  logic [7:0] mem_addr, mem_wdata;
  logic       RegWrite_WB, ResultSrc_WB;
  logic [7:0] alu_result_WB, mem_data_WB;
  logic [2:0] rd_WB;

  always #5 clk = ~clk;

  stage_mem #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .valid_MEM(valid_MEM), .RegWrite_MEM(RegWrite_MEM),
    .ResultSrc_MEM(ResultSrc_MEM), .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM),
    .alu_result_MEM(alu_result_MEM), .store_data_MEM(store_data_MEM), .rd_MEM(rd_MEM),
    .flush(flush), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .stall_MEM(stall_MEM),
    .mem_err(mem_err), .RegWrite_WB(RegWrite_WB), .ResultSrc_WB(ResultSrc_WB),
    .alu_result_WB(alu_result_WB), .mem_data_WB(mem_data_WB), .rd_WB(rd_WB)
  );

  typedef struct {
    logic       valid, rw, rs, mr, mw;
    logic [7:0] alu, sd;
    logic [2:0] rd;
    logic       flush;
  } instr_t;

  typedef struct {
    instr_t      ins;
    logic        ack;
    logic        exp_stall;
    logic [20:0] exp_wb;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [20:0] exp_q[$];
  vec_t        vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic instr_t mk(input logic v, input logic rw, input logic rs, input logic mr,
                                input logic mw, input logic [7:0] alu, input logic [7:0] sd,
                                input logic [2:0] rd, input logic fl);
    instr_t i;
    i.valid = v; i.rw = rw; i.rs = rs; i.mr = mr; i.mw = mw;
    i.alu = alu; i.sd = sd; i.rd = rd; i.flush = fl;
    return i;
  endfunction

  function automatic logic [20:0] wbv(input logic rw, input logic rs, input logic [7:0] alu,
                                      input logic [7:0] data, input logic [2:0] rd);
    return {rw, rs, alu, data, rd};
  endfunction

  function automatic logic [20:0] wb_now();
    return {RegWrite_WB, ResultSrc_WB, alu_result_WB, mem_data_WB, rd_WB};
  endfunction

  task automatic drive(input instr_t i);
    valid_MEM = i.valid; RegWrite_MEM = i.rw; ResultSrc_MEM = i.rs;
    MemRead_MEM = i.mr; MemWrite_MEM = i.mw; alu_result_MEM = i.alu;
    store_data_MEM = i.sd; rd_MEM = i.rd; flush = i.flush;
  endtask

  task automatic idle_inputs();
    drive(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 3'd0, 0));
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, 32'(mem_req), 0);
    chk({tag, "_we"}, 32'(mem_we), 0);
    chk({tag, "_addr"}, 32'(mem_addr), 0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 0);
    chk({tag, "_err"}, 32'(mem_err), 0);
    chk({tag, "_wb"}, 32'(wb_now()), 0);
  endtask

  // Issue one instruction from IDLE. d = WAIT cycles without ack before the
  // ack; d > T means the memory never answers.
  task automatic run_instr(input instr_t ins, input int d, input logic [7:0] rdata,
                           input logic flush_wait);
    logic        acc, tmo;
    int          n_wait;
    logic [20:0] exp_wb;
    acc    = ins.valid && (ins.mr || ins.mw) && !ins.flush;
    tmo    = acc && (d > T);
    n_wait = (d > T) ? T + 1 : d + 1;
    if (!acc)
      exp_wb = (ins.valid && !ins.flush && !ins.mr && !ins.mw) ?
               wbv(ins.rw, ins.rs, ins.alu, 8'h00, ins.rd) : '0;
    else if (tmo)
      exp_wb = wbv(1'b0, ins.rs, ins.alu, 8'h00, ins.rd);
    else
      exp_wb = wbv(ins.rw, ins.rs, ins.alu, ins.mw ? 8'h00 : rdata, ins.rd);
    exp_q.push_back(exp_wb);

    @(negedge clk);
    drive(ins);
    mem_ack = 1'b0;
    #1 chk("stall_accept", 32'(stall_MEM), 32'(acc));
    @(posedge clk);
    for (int k = 0; acc && k < n_wait; k++) begin
      #1;
      chk("req_wait", 32'(mem_req), 1);
      chk("addr_wait", 32'(mem_addr), 32'(ins.alu));
      chk("we_wait", 32'(mem_we), 32'(ins.mw));
      chk("wdata_wait", 32'(mem_wdata), 32'(ins.sd));
      @(negedge clk);
      if (flush_wait) flush = 1'b1;
      mem_ack   = (k == d);
      mem_rdata = (k == d) ? rdata : 8'($urandom);
      #1 chk("stall_wait", 32'(stall_MEM), 32'(k != n_wait - 1));
      @(posedge clk);
    end
    #1;
    chk("wb", 32'(wb_now()), 32'(exp_q.pop_front()));
    chk("req_done", 32'(mem_req), 0);
    chk("we_done", 32'(mem_we), 0);
    chk("err_done", 32'(mem_err), 32'(tmo));
    @(negedge clk);
    idle_inputs();
    @(posedge clk);
    #1;
    chk("err_pulse", 32'(mem_err), 0);
    chk("wb_bubble", 32'(RegWrite_WB), 0);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    chk("reset_stall", 32'(stall_MEM), 0);
    @(negedge clk);
    reset = 1'b0;

    // Single-cycle behaviour from IDLE; none of these starts an access.
    vecs[0] = '{mk(1, 1, 0, 0, 0, 8'h3C, 8'h00, 3'd5, 0), 1'b0, 1'b0, wbv(1, 0, 8'h3C, 8'h00, 3'd5)};
    vecs[1] = '{mk(0, 1, 0, 1, 0, 8'h55, 8'h12, 3'd3, 0), 1'b0, 1'b0, '0};
    vecs[2] = '{mk(1, 1, 1, 1, 0, 8'h20, 8'h00, 3'd4, 1), 1'b0, 1'b0, '0};
    vecs[3] = '{mk(1, 1, 0, 0, 0, 8'h77, 8'h00, 3'd6, 1), 1'b0, 1'b0, '0};
    vecs[4] = '{mk(1, 1, 0, 0, 0, 8'h81, 8'h00, 3'd1, 0), 1'b1, 1'b0, wbv(1, 0, 8'h81, 8'h00, 3'd1)};
    vecs[5] = '{mk(1, 0, 1, 0, 0, 8'h99, 8'h00, 3'd7, 0), 1'b0, 1'b0, wbv(0, 1, 8'h99, 8'h00, 3'd7)};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(vecs[i].ins);
      mem_ack   = vecs[i].ack;
      mem_rdata = 8'hC7;
      #1 chk("vec_stall", 32'(stall_MEM), 32'(vecs[i].exp_stall));
      @(posedge clk);
      #1;
      chk("vec_req", 32'(mem_req), 0);
      chk("vec_wb", 32'(wb_now()), 32'(vecs[i].exp_wb));
      @(negedge clk);
      idle_inputs();
    end

    // Directed handshake cases.
    run_instr(mk(1, 1, 1, 1, 0, 8'h20, 8'h00, 3'd3, 0), 2, 8'hA5, 0);
    run_instr(mk(1, 0, 0, 0, 1, 8'h10, 8'h7E, 3'd0, 0), 0, 8'hFF, 0);
    run_instr(mk(1, 1, 1, 1, 0, 8'h40, 8'h00, 3'd2, 0), T + 3, 8'h11, 0);
    run_instr(mk(1, 1, 1, 1, 0, 8'h41, 8'h00, 3'd6, 0), T, 8'h66, 0);
    run_instr(mk(1, 1, 1, 1, 0, 8'h42, 8'h00, 3'd5, 0), 1, 8'h3D, 1);
    run_instr(mk(1, 1, 0, 1, 1, 8'h43, 8'h9C, 3'd4, 0), 1, 8'hAA, 0);

    // Reset while waiting: request dropped and a late ack is ignored.
    @(negedge clk);
    drive(mk(1, 1, 1, 1, 0, 8'h44, 8'h00, 3'd2, 0));
    @(posedge clk);
    #1 chk("rst_wait_req", 32'(mem_req), 1);
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1 chk_all_zero("rst_wait");
    @(negedge clk);
    reset = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 8'hEE;
    @(posedge clk);
    #1;
    chk("late_ack_req", 32'(mem_req), 0);
    chk("late_ack_wb", 32'(wb_now()), 0);
    @(negedge clk);
    idle_inputs();

    // Back-to-back: load with immediate ack, store accepted right after.
    @(negedge clk);
    drive(mk(1, 1, 1, 1, 0, 8'h30, 8'h00, 3'd2, 0));
    @(posedge clk);
    @(negedge clk);
    mem_ack = 1'b1;
    mem_rdata = 8'h5A;
    #1 chk("b2b_stall_ack", 32'(stall_MEM), 0);
    @(posedge clk);
    #1;
    chk("b2b_load_wb", 32'(wb_now()), 32'(wbv(1, 1, 8'h30, 8'h5A, 3'd2)));
    @(negedge clk);
    mem_ack = 1'b0;
    drive(mk(1, 0, 0, 0, 1, 8'h31, 8'hC3, 3'd0, 0));
    #1 chk("b2b_stall_accept", 32'(stall_MEM), 1);
    @(posedge clk);
    #1;
    chk("b2b_req", 32'(mem_req), 1);
    chk("b2b_wdata", 32'(mem_wdata), 32'h C3);
    chk("b2b_bubble", 32'(wb_now()), 0);
    @(negedge clk);
    mem_ack = 1'b1;
    @(posedge clk);
    #1;
    chk("b2b_store_wb", 32'(wb_now()), 32'(wbv(0, 0, 8'h31, 8'h00, 3'd0)));
    @(negedge clk);
    idle_inputs();

    // Randomized instruction stream.
    for (int n = 0; n < 40; n++) begin
      instr_t ins;
      ins = mk($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
               3'($urandom), $urandom_range(0, 7) == 0);
      run_instr(ins, int'($urandom_range(0, T + 2)), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
